console_io_controller: RTL
==========================

# console_io_controller

Sequences the byte-wide console link between the processor's memory-mapped I/O and the UART bridge in Wrapper. Runs the CONSOLE_IN valid/ack receive handshake, buffers received bytes for the processor, and queues processor writes onto the CONSOLE_OUT valid/ready channel. In echo builds, it also arbitrates TX FIFO access between processor writes and received-byte echo.

## Interface
- DEPTH, 4: entries per FIFO (RX and TX); power of two, ≥2
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- CONSOLE_IN  in  8  received byte from UART bridge
- CONSOLE_IN_valid  in  1  CONSOLE_IN holds a new byte; held high until ack seen and released
- CONSOLE_IN_ack  out  1  one-cycle acknowledge of a captured byte
- CONSOLE_OUT  out  8  byte to transmit
- CONSOLE_OUT_valid  out  1  CONSOLE_OUT is valid
- CONSOLE_OUT_ready  in  1  UART bridge accepts CONSOLE_OUT this cycle
- CPU_RD_RX  in  1  processor pops RX head (one pulse per byte)
- RX_DATA  out  8  RX FIFO head; 0 when empty
- RX_AVAIL  out  1  RX FIFO non-empty
- CPU_WR_TX  in  1  processor pushes CPU_TX_DATA into TX FIFO
- CPU_TX_DATA  in  8  byte to queue
- TX_FULL  out  1  TX FIFO full
- TX_OVF  out  1  sticky: a CPU_WR_TX was dropped because TX was full

## Operation
- Receive FSM states: IDLE, ACK, WAIT_LOW.
  - IDLE: when CONSOLE_IN_valid=1 and the capture condition holds, push CONSOLE_IN into RX, then go to ACK. Otherwise stay in IDLE.
  - ACK: CONSOLE_IN_ack=1 for exactly this one state. Unconditionally go to WAIT_LOW.
  - WAIT_LOW: ack=0. When CONSOLE_IN_valid=0, go to IDLE. A byte is never captured twice, even if valid stays high.
- Capture condition: RX not full. The echo build adds further conditions (see Configuration).
- RX FIFO: CPU_RD_RX pops when non-empty; a pop on empty is ignored. A push and a pop in the same cycle both occur, leaving the count unchanged. A push is blocked when RX is full at the start of the cycle, even if a pop happens in that same cycle.
- TX FIFO: CPU_WR_TX pushes when not full. A write while full is dropped and sets TX_OVF. A CPU write and a CONSOLE_OUT handshake in the same cycle both occur. A write while full is dropped even if a drain happens in that same cycle.
- CONSOLE_OUT_valid = TX non-empty. CONSOLE_OUT = TX head, or 0 when empty. A pop occurs on valid&ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits.

## Timing
- Reset values: FSM=IDLE, both FIFOs empty, CONSOLE_IN_ack=0, CONSOLE_OUT_valid=0, CONSOLE_OUT=0, RX_DATA=0, RX_AVAIL=0, TX_FULL=0, TX_OVF=0.
- RESET asserted mid-handshake (ACK or WAIT_LOW) returns the FSM to IDLE and discards all buffered data.
- Receive latency: valid is sampled high in IDLE at edge k. The byte is pushed and ack goes high after edge k. Ack drops after edge k+1. RX_AVAIL and RX_DATA update after edge k.
- Minimum turnaround: 3 cycles per byte (capture, ack, at least one WAIT_LOW cycle with valid low).
- Transmit latency: CPU_WR_TX at edge k makes CONSOLE_OUT_valid high after edge k. CONSOLE_OUT is stable while valid=1 and ready=0.
- Back-to-back CPU writes at one per cycle are accepted until TX is full. Sustained throughput is one byte per cycle when ready=1.
- All outputs are registered or derived from registered state. There is no combinational path from any input to any output.

## Configuration
- CONSOLE_ECHO_EN defined: every captured RX byte is also pushed into TX in the same cycle.
  - The capture condition becomes: RX not full AND TX not full AND CPU_WR_TX=0.
  - The processor write has priority. A capture pending in a cycle with CPU_WR_TX=1 is deferred, and the FSM stays in IDLE.
  - An echo push never sets TX_OVF.
- CONSOLE_ECHO_EN undefined: TX is fed only by CPU_WR_TX. The capture condition is RX not full.

## Test plan
- Reset then three handshakes: CONSOLE_IN=0x50, 0x41, 0x0D, each with valid held until ack falls → exactly 3 single-cycle ack pulses. RX pops yield 0x50, 0x41, 0x0D in order. RX_AVAIL=0 afterwards.
- Valid held high 10 cycles after ack → one capture only. FSM stays in WAIT_LOW until valid=0.
- Fill RX with DEPTH bytes without popping, then present 0x7E → no ack while full. Pop once → 0x7E is captured within 1 cycle, then ack.
- CONSOLE_OUT_ready=0, write 0x43,0x47,0x33,0x32,0x99 with DEPTH=4 → TX_FULL=1, 0x99 dropped, TX_OVF=1. Set ready=1 → output is 0x43,0x47,0x33,0x32 on consecutive cycles, then valid=0.
- RESET pulsed during the ACK state with 2 bytes in RX and 3 in TX → the next cycle shows all outputs at reset values. A new 0x55 handshake completes normally.
- CONSOLE_ECHO_EN: receive 0x41 with ready=1 → CONSOLE_OUT=0x41 valid appears after the capture edge. The same-cycle combination CPU_WR_TX=1 (0x42) plus valid=1 → 0x42 is queued first, the capture is deferred 1 cycle, and the output order is 0x42, 0x41.

Source files
------------

// File: rtl/console_io_controller.sv
// console_io_controller: CONSOLE_IN valid/ack receiver with RX/TX byte FIFOs for CPU MMIO.
// Define CONSOLE_ECHO_EN to echo captured bytes into TX (CPU writes take priority).
module console_io_controller #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] CONSOLE_IN,
    input  logic       CONSOLE_IN_valid,
    output logic       CONSOLE_IN_ack,
    output logic [7:0] CONSOLE_OUT,
    output logic       CONSOLE_OUT_valid,
    input  logic       CONSOLE_OUT_ready,
    input  logic       CPU_RD_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_AVAIL,
    input  logic       CPU_WR_TX,
    input  logic [7:0] CPU_TX_DATA,
    output logic       TX_FULL,
    output logic       TX_OVF
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
    state_t        state_q, state_d;
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d;
    logic          rx_full, tx_full, capture, echo, rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0]    tx_din;

    always_comb begin
        rx_full = rx_cnt_q == FULL;
        tx_full = tx_cnt_q == FULL;
`ifdef CONSOLE_ECHO_EN
        capture = state_q == IDLE && CONSOLE_IN_valid && !rx_full && !tx_full && !CPU_WR_TX;
        echo    = capture;
`else
        capture = state_q == IDLE && CONSOLE_IN_valid && !rx_full;
        echo    = 1'b0;
`endif
        rx_push  = capture;
        rx_pop   = CPU_RD_RX && rx_cnt_q != '0;
        tx_push  = (CPU_WR_TX && !tx_full) || echo;
        tx_pop   = tx_cnt_q != '0 && CONSOLE_OUT_ready;
        tx_din   = echo ? CONSOLE_IN : CPU_TX_DATA;
        state_d  = capture ? ACK :
                   state_q == ACK ? WAIT_LOW :
                   (state_q == WAIT_LOW && !CONSOLE_IN_valid) ? IDLE : state_q;
        rx_mem_d = rx_mem_q;
        tx_mem_d = tx_mem_q;
        if (rx_push) rx_mem_d[rx_wr_q] = CONSOLE_IN;
        if (tx_push) tx_mem_d[tx_wr_q] = tx_din;
        rx_wr_d  = rx_wr_q + AW'(rx_push);
        rx_rd_d  = rx_rd_q + AW'(rx_pop);
        tx_wr_d  = tx_wr_q + AW'(tx_push);
        tx_rd_d  = tx_rd_q + AW'(tx_pop);
        rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        // echo pushes never reach here with CPU_WR_TX high, so overflow is CPU-only
        tx_ovf_d = tx_ovf_q || (CPU_WR_TX && tx_full);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

    assign CONSOLE_IN_ack    = state_q == ACK;
    assign RX_AVAIL          = rx_cnt_q != '0;
    assign RX_DATA           = RX_AVAIL ? rx_mem_q[rx_rd_q] : 8'h00;
    assign CONSOLE_OUT_valid = tx_cnt_q != '0;
    assign CONSOLE_OUT       = CONSOLE_OUT_valid ? tx_mem_q[tx_rd_q] : 8'h00;
    assign TX_FULL           = tx_full;
    assign TX_OVF            = tx_ovf_q;
endmodule
